// File: rtl/sc_lanetick_scheduler.sv
// ---------------------------------------------------------------------------
// sc_lanetick_scheduler
//
// Generates lane-movement events for the Frogger playfield and shares the
// single matrix-shift port among all lanes. A common prescaler produces a
// base tick; each lane has its own period counter whose period shrinks with
// the current level. Expired lanes raise a pending flag, and a round-robin
// arbiter issues them one at a time to the matrix datapath.
//
// Optional build macro: SC_LANETICKSCHEDULER_PAUSE_EN
//   Defined   : adds SC_LANETICKSCHEDULER_Pause_InLow; while it is low the
//               prescaler and lane counters freeze (no ticks), while pending
//               flags, the handshake and level strobes carry on normally.
//   Undefined : no pause port, counting is never paused.
//
// Ports
//   SC_LANETICKSCHEDULER_CLOCK_50          in   system clock
//   SC_LANETICKSCHEDULER_RESET_InLow       in   synchronous active-low reset
//   SC_LANETICKSCHEDULER_SpeedClear_InLow  in   low: clear timing state, force IDLE
//   SC_LANETICKSCHEDULER_LevelUp_InLow     in   strobe: level+1 (saturating)
//   SC_LANETICKSCHEDULER_LevelClear_InLow  in   strobe: level := 0 (wins over LevelUp)
//   SC_LANETICKSCHEDULER_ShiftReady_InHigh in   matrix port accepts a shift
//   SC_LANETICKSCHEDULER_Pause_InLow       in   (PAUSE_EN builds only)
//   SC_LANETICKSCHEDULER_ShiftValid_OutHigh out shift request valid
//   SC_LANETICKSCHEDULER_ShiftLane_OutBUS  out  lane index of the request
//   SC_LANETICKSCHEDULER_Level_OutBUS      out  current level
//   SC_LANETICKSCHEDULER_Pending_OutBUS    out  pending-request flags
//   SC_LANETICKSCHEDULER_Overrun_OutBUS    out  sticky per-lane overrun flags
//   o_dbg_state                            out  arbiter FSM state (0 IDLE, 1 RUN, 2 GRANT)
//
// Handshake: a shift transfers in any cycle where ShiftValid and ShiftReady
// are both high. Once ShiftValid rises, ShiftLane is held stable until the
// transfer; the only way a raised request is withdrawn is SpeedClear going
// low, which drops ShiftValid on the next edge.
// ---------------------------------------------------------------------------
module sc_lanetick_scheduler #(
    parameter int LANES          = 4,
    parameter int PRESCALE_COUNT = 500000,
    parameter int PERIOD_BASE    = 40,
    parameter int LANE_OFFSET    = 6,
    parameter int PERIOD_STEP    = 4,
    parameter int PERIOD_MIN     = 4,
    parameter int LEVEL_MAX      = 7
) (
    input  logic             SC_LANETICKSCHEDULER_CLOCK_50,
    input  logic             SC_LANETICKSCHEDULER_RESET_InLow,
    input  logic             SC_LANETICKSCHEDULER_SpeedClear_InLow,
    input  logic             SC_LANETICKSCHEDULER_LevelUp_InLow,
    input  logic             SC_LANETICKSCHEDULER_LevelClear_InLow,
    input  logic             SC_LANETICKSCHEDULER_ShiftReady_InHigh,
`ifdef SC_LANETICKSCHEDULER_PAUSE_EN
    input  logic             SC_LANETICKSCHEDULER_Pause_InLow,
`endif
    output logic             SC_LANETICKSCHEDULER_ShiftValid_OutHigh,
    output logic [2:0]       SC_LANETICKSCHEDULER_ShiftLane_OutBUS,
    output logic [2:0]       SC_LANETICKSCHEDULER_Level_OutBUS,
    output logic [LANES-1:0] SC_LANETICKSCHEDULER_Pending_OutBUS,
    output logic [LANES-1:0] SC_LANETICKSCHEDULER_Overrun_OutBUS,
    output logic [1:0]       o_dbg_state
);

    localparam int PS_W = (PRESCALE_COUNT > 1) ? $clog2(PRESCALE_COUNT) : 1;
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    logic                  w_clk;
    logic                  w_rst_n;
    logic                  w_sc_n;
    logic                  w_count_en;
    logic                  w_tick;
    logic                  w_hs;
    logic                  w_found;
    logic [2:0]            w_rr_idx;
    logic [LW-1:0]         v_try;
    logic [LANES-1:0]      w_expire;
    logic [LANES-1:0]      w_hs_clr;
    logic [LANES-1:0][9:0] w_raw;
    logic [LANES-1:0][9:0] w_period;
    state_t                w_state_next;

    logic [PS_W-1:0]       r_ps;
    logic [LANES-1:0][9:0] r_cnt;
    logic [LANES-1:0]      r_pending;
    logic [LANES-1:0]      r_overrun;
    logic [2:0]            r_level;
    logic [2:0]            r_lane;
    logic [2:0]            r_last;
    logic                  r_valid;
    state_t                r_state;

    assign w_clk   = SC_LANETICKSCHEDULER_CLOCK_50;
    assign w_rst_n = SC_LANETICKSCHEDULER_RESET_InLow;
    assign w_sc_n  = SC_LANETICKSCHEDULER_SpeedClear_InLow;

`ifdef SC_LANETICKSCHEDULER_PAUSE_EN
    assign w_count_en = w_sc_n & SC_LANETICKSCHEDULER_Pause_InLow;
`else
    assign w_count_en = w_sc_n;
`endif

    assign w_tick = w_count_en && (r_ps == PS_W'(PRESCALE_COUNT - 1));
    assign w_hs   = (r_state == ST_GRANT) && SC_LANETICKSCHEDULER_ShiftReady_InHigh;

    // Per-lane period in 10-bit two's complement; anything below the floor
    // (including negative results at high levels) is clamped to PERIOD_MIN.
    always_comb begin
        w_raw    = '0;
        w_period = '0;
        w_expire = '0;
        w_hs_clr = '0;
        for (int i = 0; i < LANES; i++) begin
            w_raw[i] = 10'(PERIOD_BASE + i * LANE_OFFSET) - 10'(PERIOD_STEP) * {7'd0, r_level};
            if ($signed(w_raw[i]) < $signed(10'(PERIOD_MIN)))
                w_period[i] = 10'(PERIOD_MIN);
            else
                w_period[i] = w_raw[i];
            // >= rather than == so a period shortened mid-count still expires
            w_expire[i] = w_tick && (r_cnt[i] >= w_period[i] - 10'd1);
            w_hs_clr[i] = w_hs && (r_lane == 3'(i));
        end
    end

    // Round-robin: first pending lane after the last granted one, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = 3'd0;
        v_try    = '0;
        for (int k = 1; k <= LANES; k++) begin
            v_try = LW'((int'(r_last) + k) % LANES);
            if (!w_found && r_pending[v_try]) begin
                w_found  = 1'b1;
                w_rr_idx = 3'(v_try);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_RUN;
            ST_RUN:   if (w_found) w_state_next = ST_GRANT;
            ST_GRANT: if (SC_LANETICKSCHEDULER_ShiftReady_InHigh) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
        if (!w_sc_n)
            w_state_next = ST_IDLE;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (w_state_next == ST_GRANT);
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_lane <= 3'd0;
            r_last <= 3'(LANES - 1);
        end else begin
            if (r_state == ST_RUN && w_found && w_sc_n)
                r_lane <= w_rr_idx;
            if (w_hs)
                r_last <= r_lane;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n || !w_sc_n) begin
            r_ps      <= '0;
            r_cnt     <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            if (w_count_en)
                r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
            if (w_tick) begin
                for (int i = 0; i < LANES; i++)
                    r_cnt[i] <= w_expire[i] ? 10'd0 : r_cnt[i] + 10'd1;
            end
            // A same-cycle grant and expiry leaves the lane pending without overrun.
            r_pending <= (r_pending & ~w_hs_clr) | w_expire;
            r_overrun <= r_overrun | (w_expire & r_pending & ~w_hs_clr);
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n)
            r_level <= 3'd0;
        else if (!SC_LANETICKSCHEDULER_LevelClear_InLow)
            r_level <= 3'd0;
        else if (!SC_LANETICKSCHEDULER_LevelUp_InLow && (r_level < 3'(LEVEL_MAX)))
            r_level <= r_level + 3'd1;
    end

    assign SC_LANETICKSCHEDULER_ShiftValid_OutHigh = r_valid;
    assign SC_LANETICKSCHEDULER_ShiftLane_OutBUS   = r_lane;
    assign SC_LANETICKSCHEDULER_Level_OutBUS       = r_level;
    assign SC_LANETICKSCHEDULER_Pending_OutBUS     = r_pending;
    assign SC_LANETICKSCHEDULER_Overrun_OutBUS     = r_overrun;
    assign o_dbg_state                             = r_state;

endmodule
